// File: rtl/seq_compare.sv
// seq_compare: multi-cycle chunked magnitude/equality comparator, MS chunk first with early exit
// Ports: clk, reset (sync, active-high); start/mode/inA/inB request inputs;
//        busy (scanning), done (one-cycle result strobe), outC (mode result), outEq (A==B), outLt (A<B)
module seq_compare #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic             outC,
  output logic             outEq,
  output logic             outLt
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] TOP = IW'(NCH - 1);
  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} stateT;
  stateT state, nextState;
  logic [WIDTH-1:0] aReg, bReg;
  logic [2:0] modeReg;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] flip, aChunk, bChunk;
  logic signedMode, chunkEq, chunkLt, finish, accept, resC;
  // Flipping the sign bit of the top chunk turns a two's-complement compare into an unsigned one
  always_comb begin
    signedMode = modeReg == 3'd3 || modeReg == 3'd5;
    flip = (signedMode && idx == TOP) ? MSB : '0;
    aChunk = aReg[idx*CHUNK +: CHUNK] ^ flip;
    bChunk = bReg[idx*CHUNK +: CHUNK] ^ flip;
    chunkEq = aChunk == bChunk;
    chunkLt = aChunk < bChunk;
    finish = state == COMPARE && (!chunkEq || idx == '0);
    accept = start && state != COMPARE;
    resC = modeReg == 3'd0 ? chunkEq :
           modeReg == 3'd1 ? !chunkEq :
           (modeReg == 3'd2 || modeReg == 3'd3) ? chunkLt :
           (modeReg == 3'd4 || modeReg == 3'd5) ? !chunkLt : 1'b0;
    nextState = accept ? COMPARE : finish ? DONE : state == DONE ? IDLE : state;
    busy = state == COMPARE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      aReg <= '0;
      bReg <= '0;
      modeReg <= '0;
      idx <= '0;
      outC <= 1'b0;
      outEq <= 1'b0;
      outLt <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        aReg <= inA;
        bReg <= inB;
        modeReg <= mode;
        idx <= TOP;
      end else if (state == COMPARE) begin
        idx <= idx - 1'b1;
      end
      if (finish) begin
        outC <= resC;
        outEq <= chunkEq;
        outLt <= chunkLt;
      end
    end
  end
endmodule

// File: tb/tb_seq_compare.sv
// tb_seq_compare: directed table-driven bench for seq_compare plus hand-written corner sequences
module tb_seq_compare;
  logic clk = 0, reset = 1, start = 0;
  logic [2:0] mode = '0;
  logic [31:0] inA = '0, inB = '0;
  logic busy, done, outC, outEq, outLt;
  logic busy1, done1, outC1, outEq1, outLt1;
  int checks = 0, errors = 0, overlap = 0;
  always #5 clk = ~clk;
  seq_compare #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .outC(outC), .outEq(outEq), .outLt(outLt));
  seq_compare #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .inA(inA), .inB(inB),
    .busy(busy1), .done(done1), .outC(outC1), .outEq(outEq1), .outLt(outLt1));
  always @(negedge clk) if ((busy && done) || (busy1 && done1)) overlap++;
  typedef struct {
    logic [2:0] mode;
    logic [31:0] a, b;
    int cyc;
    logic c, eq, lt;
  } vecT;
  vecT vecs[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic startOp(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1; mode = m; inA = a; inB = b;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic waitDone(input int base, output int n, output int n1, output int busyN);
    n = base;
    n1 = done1 ? base : 0;
    busyN = busy ? 1 : 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1 n++;
      if (done1 && n1 == 0) n1 = n;
      if (busy) busyN++;
    end
  endtask
  initial begin
    int n, n1, bn, quiet;
    vecs = '{
      '{3'd0, 32'h0000_0000, 32'h0000_0000, 5, 1'b1, 1'b1, 1'b0},
      '{3'd0, 32'h0000_0001, 32'h0000_0000, 5, 1'b0, 1'b0, 1'b0},
      '{3'd1, 32'h0000_0001, 32'h0000_0000, 5, 1'b1, 1'b0, 1'b0},
      '{3'd2, 32'h0000_0001, 32'h8000_0000, 2, 1'b1, 1'b0, 1'b1},
      '{3'd3, 32'h0000_0001, 32'h8000_0000, 2, 1'b0, 1'b0, 1'b0},
      '{3'd5, 32'h0000_0001, 32'h8000_0000, 2, 1'b1, 1'b0, 1'b0},
      '{3'd4, 32'h0000_0001, 32'h8000_0000, 2, 1'b0, 1'b0, 1'b1},
      '{3'd7, 32'h1234_5678, 32'h1234_5678, 5, 1'b0, 1'b1, 1'b0},
      '{3'd2, 32'h0000_0100, 32'h0000_0200, 4, 1'b1, 1'b0, 1'b1},
      '{3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b1, 1'b0, 1'b1},
      '{3'd4, 32'h0000_00FF, 32'h0000_00FE, 5, 1'b1, 1'b0, 1'b0},
      '{3'd6, 32'h0000_0005, 32'h0000_0003, 5, 1'b0, 1'b0, 1'b0},
      '{3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 1'b0, 1'b1, 1'b0}
    };
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", {busy, done, outC, outEq, outLt}, 5'b0);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 13; i++) begin
      startOp(vecs[i].mode, vecs[i].a, vecs[i].b);
      waitDone(1, n, n1, bn);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].cyc);
      chk($sformatf("v%0d_busy", i), bn, vecs[i].cyc - 1);
      chk($sformatf("v%0d_result", i), {outC, outEq, outLt}, {vecs[i].c, vecs[i].eq, vecs[i].lt});
      chk($sformatf("v%0d_nch1_cycles", i), n1, 2);
      chk($sformatf("v%0d_nch1_result", i), {outC1, outEq1, outLt1}, {vecs[i].c, vecs[i].eq, vecs[i].lt});
    end
    startOp(3'd2, 32'h0000_0001, 32'h0000_0002);
    @(negedge clk);
    start = 1; mode = 3'd0; inA = 32'h0; inB = 32'h0;
    @(posedge clk);
    #1 start = 0;
    waitDone(2, n, n1, bn);
    chk("ignored_start_cycles", n, 5);
    chk("ignored_start_result", {outC, outEq, outLt}, 3'b101);
    @(negedge clk);
    start = 1; mode = 3'd2; inA = 32'h8000_0000; inB = 32'h0000_0001;
    @(posedge clk);
    #1 start = 0;
    chk("done_start_busy", {busy, done}, 2'b10);
    waitDone(1, n, n1, bn);
    chk("done_start_cycles", n, 2);
    chk("done_start_result", {outC, outEq, outLt}, 3'b000);
    startOp(3'd0, 32'h5, 32'h5);
    waitDone(1, n, n1, bn);
    chk("pre_reset_result", {outC, outEq, outLt}, 3'b110);
    startOp(3'd0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1 chk("abort_outputs", {busy, done, outC, outEq, outLt}, 5'b0);
    @(negedge clk);
    start = 1; mode = 3'd0;
    @(posedge clk);
    #1 chk("reset_beats_start", {busy, done}, 2'b0);
    start = 0;
    @(negedge clk) reset = 0;
    quiet = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (done || busy) quiet++;
    end
    chk("no_done_after_abort", quiet, 0);
    startOp(3'd0, 32'h0, 32'h0);
    waitDone(1, n, n1, bn);
    chk("post_reset_cycles", n, 5);
    chk("post_reset_result", {outC, outEq, outLt}, 3'b110);
    @(negedge clk);
    chk("busy_done_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_compare.md
SEQ_COMPARE -- requirements
Module: seq_compare

Interface
REQ-001 Parameter WIDTH, 32, operand width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, 8, bits compared per cycle; NCH = WIDTH/CHUNK.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  request; accepted only in IDLE or DONE.
REQ-006 Port mode  input  3  0=EQ, 1=NE, 2=LTU, 3=LTS, 4=GEU, 5=GES, 6/7=reserved.
REQ-007 Port inA  input  WIDTH  operand A; sampled on accepted start only.
REQ-008 Port inB  input  WIDTH  operand B; sampled on accepted start only.
REQ-009 Port busy  output  1  high while in COMPARE.
REQ-010 Port done  output  1  one-cycle pulse; result valid.
REQ-011 Port outC  output  1  mode result; registered, held until next done.
REQ-012 Port outEq  output  1  A==B; updated with outC.
REQ-013 Port outLt  output  1  A<B (signed for modes 3/5, else unsigned); updated with outC.

Function
REQ-014 FSM states IDLE, COMPARE, DONE; SHALL be the only states.
REQ-015 Accepted start (IDLE or DONE): latch inA, inB and mode, set chunk index to NCH-1, go to COMPARE.
REQ-016 start in COMPARE SHALL be ignored; latched operands and mode SHALL NOT change.
REQ-017 COMPARE: one chunk per cycle, most-significant chunk first, index decrementing.
REQ-018 Signed modes (3, 5): the MSB of chunk NCH-1 SHALL be inverted on both operands before comparing; all other chunks are compared unsigned.
REQ-019 First unequal chunk: outLt = (A chunk < B chunk), outEq = 0; go to DONE (early termination).
REQ-020 Chunk 0 equal after all higher chunks equal: outEq = 1, outLt = 0; go to DONE.
REQ-021 outC: EQ=outEq, NE=!outEq, LTU/LTS=outLt, GEU/GES=!outLt, reserved=0.
REQ-022 outC, outEq and outLt SHALL be written on the COMPARE->DONE edge, so they are valid while done=1 and held until the next done.
REQ-023 DONE lasts exactly one cycle with done=1; next state COMPARE if start, else IDLE.
REQ-024 Latency: with start sampled at edge 0, done is high in cycle m+1, where m (1..NCH) is the number of chunks examined; equal operands take NCH+1 cycles.
REQ-025 busy and done SHALL never be high in the same cycle.
REQ-026 Reserved modes: normal scan and latency; outEq and outLt valid; outC=0.
REQ-027 NCH=1 (CHUNK=WIDTH): every compare SHALL complete in 2 cycles.

Reset
REQ-028 reset high at a clock edge: state=IDLE; busy, done, outC, outEq, outLt = 0; operand and mode registers cleared.
REQ-029 reset SHALL override start and abort COMPARE or DONE with no done pulse; reset takes priority when asserted together with start.
REQ-030 The first start is accepted on the first edge after reset deasserts.

Verification (WIDTH=32, CHUNK=8)
REQ-031 EQ, A=0, B=0 -> busy cycles 1-4, done in cycle 5, outC=1, outEq=1, outLt=0.
REQ-032 EQ then NE, A=1, B=0 -> difference in chunk 0, done in cycle 5; EQ outC=0, NE outC=1, outLt=0.
REQ-033 A=32'h0000_0001, B=32'h8000_0000 -> done in cycle 2; LTU outC=1; LTS outC=0 with outLt=0; GES outC=1.
REQ-034 start pulsed during busy with different operands -> ignored, result reflects the original operands; start held during the DONE cycle -> accepted, busy in the next cycle.
REQ-035 reset asserted in cycle 2 of an EQ compare -> next cycle IDLE, all outputs 0, no done pulse; a new start then completes normally.
REQ-036 mode=7, A=B=32'h1234_5678 -> done in cycle 5, outC=0, outEq=1.
